// File: rtl/uvmt_i2c_st_c2t_rx.sv
// C2T lane receiver: decodes preamble/start/data/parity framing into bytes.
// Ports: c2t_clk/c2t_reset, c2tp/c2tn symbols, out_valid/out_data/out_ready
// byte FIFO, frame_err/parity_err/overflow pulses, busy (FSM not hunting).
// Optional macro UVMT_I2C_ST_C2T_RX_ERR_CNT_EN adds err_count[15:0].
module uvmt_i2c_st_c2t_rx #(
  parameter int PREAMBLE_LEN = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       c2t_clk,
  input  logic       c2t_reset,
  input  logic       c2tp,
  input  logic       c2tn,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overflow,
  output logic       busy
`ifdef UVMT_I2C_ST_C2T_RX_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    PARITY
  } state_t;

  state_t      r_state;
  logic [3:0]  r_ones;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_frame_err;
  logic        r_parity_err;
  logic        r_overflow;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0] r_cnt;

  logic w_idle;
  logic w_one;
  logic w_zero;
  logic w_ill;
  logic w_bit;
  logic w_par_ok;
  logic w_push_req;
  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_ovf;

  assign w_idle = ~c2tp & ~c2tn;
  assign w_one  =  c2tp & ~c2tn;
  assign w_zero = ~c2tp &  c2tn;
  assign w_ill  =  c2tp &  c2tn;
  assign w_bit  = w_one | w_zero;

  // Data bit value equals c2tp for ONE/ZERO symbols.
  assign w_par_ok   = ~(^{r_shift, c2tp});
  assign w_push_req = (r_state == PARITY) & w_bit & w_par_ok;

  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_full    = (r_cnt == FULL_CNT);
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_wr      = w_push_req & (~w_full | w_pop);
  assign w_ovf     = w_push_req & w_full & ~w_pop;

  assign out_data   = r_mem[r_rp];
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overflow   = r_overflow;
  assign busy       = (r_state != HUNT);

  always_ff @(posedge c2t_clk) begin
    if (c2t_reset) begin
      r_state      <= HUNT;
      r_ones       <= '0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      unique case (r_state)
        HUNT: begin
          unique case (1'b1)
            w_ill: begin
              r_frame_err <= 1'b1;
              r_ones      <= '0;
            end
            w_one: begin
              if (r_ones != 4'hF)
                r_ones <= r_ones + 4'd1;
            end
            w_zero: begin
              r_ones <= '0;
              if (int'(r_ones) >= PREAMBLE_LEN) begin
                r_state  <= DATA;
                r_bitcnt <= '0;
              end
            end
            default: r_ones <= '0;
          endcase
        end
        DATA: begin
          if (w_bit) begin
            r_shift  <= {r_shift[6:0], c2tp};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7)
              r_state <= PARITY;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= HUNT;
          end
        end
        PARITY: begin
          r_state <= HUNT;
          r_ones  <= '0;
          if (!w_bit)
            r_frame_err <= 1'b1;
          else if (!w_par_ok)
            r_parity_err <= 1'b1;
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge c2t_clk) begin
    if (c2t_reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      r_overflow <= w_ovf;
      if (w_wr) begin
        r_mem[r_wp] <= r_shift;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef UVMT_I2C_ST_C2T_RX_ERR_CNT_EN
  // Counts each registered pulse, so it moves one cycle after the pulse.
  logic [15:0] r_err_count;
  assign err_count = r_err_count;

  always_ff @(posedge c2t_clk) begin
    if (c2t_reset)
      r_err_count <= '0;
    else if ((r_frame_err | r_parity_err | r_overflow) &&
             (r_err_count != 16'hFFFF))
      r_err_count <= r_err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_uvmt_i2c_st_c2t_rx.sv
// Bench for uvmt_i2c_st_c2t_rx: frame table, corner sequences, random frames.
// Expected results come from a frame-level model and a byte queue.
module tb_uvmt_i2c_st_c2t_rx;

  localparam int PL = 4;
  localparam int DEPTH = 4;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ONE  = 2'b10;
  localparam logic [1:0] S_ZERO = 2'b01;
  localparam logic [1:0] S_ILL  = 2'b11;

  localparam int R_NONE = 0;
  localparam int R_PUSH = 1;
  localparam int R_PERR = 2;
  localparam int R_FERR = 3;

  typedef struct {
    logic [7:0] b;
    int         pre;
    bit         flip;
    int         ab;
    logic [1:0] absym;
    int         res;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p = 1'b0;
  logic       n = 1'b0;
  logic       rdy = 1'b0;
  logic       ov_valid;
  logic [7:0] o_data;
  logic       fe;
  logic       pe;
  logic       ovf;
  logic       bsy;
`ifdef UVMT_I2C_ST_C2T_RX_ERR_CNT_EN
  logic [15:0] ecnt;
  int          e_prev = 0;
`endif

  int passed = 0;
  int total  = 0;
  int g_rdy = 0;
  int g_rdy_last = -1;
  logic [7:0] q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  uvmt_i2c_st_c2t_rx #(
    .PREAMBLE_LEN(PL),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .c2t_clk(clk),
    .c2t_reset(rst),
    .c2tp(p),
    .c2tn(n),
    .out_valid(ov_valid),
    .out_data(o_data),
    .out_ready(rdy),
    .frame_err(fe),
    .parity_err(pe),
    .overflow(ovf),
`ifdef UVMT_I2C_ST_C2T_RX_ERR_CNT_EN
    .err_count(ecnt),
`endif
    .busy(bsy)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    else
      passed++;
  endtask

  function automatic vec_t mk(logic [7:0] b, int pre, bit flip, int ab,
                              logic [1:0] absym, int res);
    vec_t v;
    v.b = b; v.pre = pre; v.flip = flip;
    v.ab = ab; v.absym = absym; v.res = res;
    return v;
  endfunction

  // Frame-level outcome straight from the framing rules.
  function automatic int ref_result(vec_t v);
    if (v.ab == 9) return R_FERR;
    if (v.pre < PL) return R_NONE;
    if (v.ab >= 0) return R_FERR;
    if (v.flip) return R_PERR;
    return R_PUSH;
  endfunction

  task automatic send_sym(input logic [1:0] sym, input bit efe,
                          input bit epe, input bit epush, input bit ebusy,
                          input logic [7:0] pb, input bit last);
    bit pre_valid;
    bit eov;
    int m;
    m = (last && g_rdy_last >= 0) ? g_rdy_last : g_rdy;
    rdy = (m == 2) ? 1'($urandom_range(0, 1)) : 1'(m);
    {p, n} = sym;
    pre_valid = (q.size() > 0);
    @(posedge clk);
    #1;
    if (pre_valid && rdy) void'(q.pop_front());
    eov = 1'b0;
    if (epush) begin
      if (q.size() < DEPTH) q.push_back(pb);
      else eov = 1'b1;
    end
    chk("flags{v,fe,pe,ov,busy}",
        {27'd0, ov_valid, fe, pe, ovf, bsy},
        {27'd0, q.size() > 0, efe, epe, eov, ebusy});
    if (q.size() > 0)
      chk("out_data", {24'd0, o_data}, {24'd0, q[0]});
`ifdef UVMT_I2C_ST_C2T_RX_ERR_CNT_EN
    chk("err_count", {16'd0, ecnt}, e_prev);
    e_prev += int'(efe) + int'(epe) + int'(eov);
`endif
  endtask

  task automatic fin(input logic [1:0] sym, input vec_t v);
    send_sym(sym, v.res == R_FERR, v.res == R_PERR,
             v.res == R_PUSH, 1'b0, v.b, 1'b1);
  endtask

  task automatic send_frame(input vec_t v);
    bit par;
    send_sym(S_IDLE, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < v.pre; i++)
      send_sym(S_ONE, 0, 0, 0, 0, 8'h00, 0);
    if (v.ab == 9) begin
      fin(S_ILL, v);
      return;
    end
    if (v.pre < PL) begin
      fin(S_ZERO, v);
      return;
    end
    send_sym(S_ZERO, 0, 0, 0, 1, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      if (v.ab == i) begin
        fin(v.absym, v);
        return;
      end
      send_sym(v.b[7-i] ? S_ONE : S_ZERO, 0, 0, 0, 1, 8'h00, 0);
    end
    par = (^v.b) ^ v.flip;
    if (v.ab == 8) fin(v.absym, v);
    else fin(par ? S_ONE : S_ZERO, v);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(mk(b, PL, 0, -1, S_IDLE, R_PUSH));
  endtask

  task automatic do_reset(input logic [1:0] sym, input string nm);
    rst = 1'b1;
    {p, n} = sym;
    rdy = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    chk(nm, {22'd0, ov_valid, o_data, fe, pe, ovf},
        32'd0);
    chk({nm, "_busy"}, {31'd0, bsy}, 32'd0);
`ifdef UVMT_I2C_ST_C2T_RX_ERR_CNT_EN
    chk({nm, "_ecnt"}, {16'd0, ecnt}, 32'd0);
    e_prev = 0;
`endif
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    do_reset(S_IDLE, "reset0");
    do_reset(S_ILL, "reset1");

    tbl.push_back(mk(8'hA5, 4, 0, -1, S_IDLE, R_PUSH));
    tbl.push_back(mk(8'h3C, 3, 0, -1, S_IDLE, R_NONE));
    tbl.push_back(mk(8'h3C, 4, 0, -1, S_IDLE, R_PUSH));
    tbl.push_back(mk(8'h01, 4, 1, -1, S_IDLE, R_PERR));
    tbl.push_back(mk(8'h55, 4, 0, 4, S_IDLE, R_FERR));
    tbl.push_back(mk(8'h00, 2, 0, 9, S_ILL, R_FERR));
    tbl.push_back(mk(8'hC3, 20, 0, -1, S_IDLE, R_PUSH));
    tbl.push_back(mk(8'h7E, 5, 0, 8, S_ILL, R_FERR));
    tbl.push_back(mk(8'h81, 4, 0, 0, S_ILL, R_FERR));
    tbl.push_back(mk(8'hFF, 1, 0, -1, S_IDLE, R_NONE));
    tbl.push_back(mk(8'h80, 6, 1, -1, S_IDLE, R_PERR));
    tbl.push_back(mk(8'h00, 4, 0, -1, S_IDLE, R_PUSH));

    g_rdy = 1;
    foreach (tbl[i]) begin
      chk("tbl_ref", ref_result(tbl[i]), tbl[i].res);
      send_frame(tbl[i]);
    end

    // Fill to full, overflow on fifth, then pop+push at full.
    g_rdy = 0;
    for (int i = 0; i < 5; i++) good(8'h10 + 8'(i));
    g_rdy_last = 1;
    good(8'h15);
    g_rdy_last = -1;
    g_rdy = 1;
    for (int i = 0; i < 6; i++)
      send_sym(S_IDLE, 0, 0, 0, 0, 8'h00, 0);

    // Push and pop together with a single entry.
    g_rdy = 0;
    good(8'h66);
    g_rdy_last = 1;
    good(8'h99);
    g_rdy_last = -1;
    g_rdy = 1;
    for (int i = 0; i < 3; i++)
      send_sym(S_IDLE, 0, 0, 0, 0, 8'h00, 0);

    // Reset mid-DATA with two bytes queued; pending frame_err suppressed.
    g_rdy = 0;
    good(8'h21);
    good(8'h42);
    send_sym(S_IDLE, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < PL; i++)
      send_sym(S_ONE, 0, 0, 0, 0, 8'h00, 0);
    send_sym(S_ZERO, 0, 0, 0, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++)
      send_sym(S_ONE, 0, 0, 0, 1, 8'h00, 0);
    do_reset(S_ILL, "reset_mid");
    send_sym(S_IDLE, 0, 0, 0, 0, 8'h00, 0);

    // Random frames with random back-pressure.
    g_rdy = 2;
    for (int k = 0; k < 40; k++) begin
      int r;
      v.b = 8'($urandom);
      v.pre = int'($urandom_range(1, 7));
      r = int'($urandom_range(0, 9));
      v.ab = (r == 0) ? int'($urandom_range(0, 8)) :
             (r == 1) ? 9 : -1;
      v.flip = ($urandom_range(0, 4) == 0);
      v.absym = $urandom_range(0, 1) ? S_ILL : S_IDLE;
      v.res = ref_result(v);
      send_frame(v);
    end
    g_rdy = 1;
    for (int i = 0; i < 6; i++)
      send_sym(S_IDLE, 0, 0, 0, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
